// File: rtl/pmem_responder.sv
// ============================================================================
// Module   : pmem_responder
// Brief    : Fixed-latency 256-bit line memory responder with protocol checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_responder #(
    parameter int LATENCY     = 8,
    parameter int DEPTH_LINES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         pmem_error
);

    localparam int         c_IDX_W = $clog2(DEPTH_LINES);
    localparam logic [7:0] c_LOAD  = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_count;
    logic                r_op_write;
    logic [26:0]         r_addr;
    logic [255:0]        r_wdata;
    logic [255:0]        r_mem [DEPTH_LINES];
    logic [255:0]        r_rdata;
    logic                r_resp;
    logic                r_error;

    logic                w_accept;
    logic                w_commit;
    logic                w_commit_write;
    logic [c_IDX_W-1:0]  w_commit_idx;
    logic [255:0]        w_commit_wdata;
    logic                w_err_set;
    logic                w_unused_low;

    assign w_unused_low = ^pmem_address[4:0];
    assign w_accept     = (r_state == S_IDLE) && (pmem_read ^ pmem_write);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (pmem_read ^ pmem_write)
                         w_next_state = (LATENCY == 1) ? S_RESP : S_BUSY;
            S_BUSY:  if (r_count == 8'd0) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_DRAIN;
            S_DRAIN: if (!pmem_read && !pmem_write) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // RESP is the cycle in which the line is read/committed; the pulse follows it.
    // With LATENCY=1 the commit happens straight from IDLE using the live inputs.
    always_comb begin
        w_commit       = (w_next_state == S_RESP) && (r_state != S_RESP);
        w_commit_write = (r_state == S_IDLE) ? pmem_write : r_op_write;
        w_commit_idx   = (r_state == S_IDLE) ? pmem_address[5 +: c_IDX_W]
                                             : r_addr[c_IDX_W-1:0];
        w_commit_wdata = (r_state == S_IDLE) ? pmem_wdata : r_wdata;
    end

    always_comb begin
        w_err_set = 1'b0;
        if (r_state == S_IDLE && pmem_read && pmem_write)
            w_err_set = 1'b1;
        if (r_state == S_BUSY &&
            (({pmem_write, pmem_read} != {r_op_write, ~r_op_write}) ||
             (pmem_address[31:5] != r_addr)))
            w_err_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 8'd0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_resp     <= 1'b0;
            r_error    <= 1'b0;
            for (int i = 0; i < DEPTH_LINES; i++)
                r_mem[i] <= '0;
        end else begin
            r_state <= w_next_state;
            r_resp  <= (r_state == S_RESP);
            if (w_err_set)
                r_error <= 1'b1;
            if (w_accept) begin
                r_op_write <= pmem_write;
                r_addr     <= pmem_address[31:5];
                r_wdata    <= pmem_wdata;
                r_count    <= c_LOAD;
            end else if (r_state == S_BUSY && r_count != 8'd0) begin
                r_count <= r_count - 8'd1;
            end
            if (w_commit) begin
                if (w_commit_write)
                    r_mem[w_commit_idx] <= w_commit_wdata;
                else
                    r_rdata <= r_mem[w_commit_idx];
            end
        end
    end

    assign pmem_resp  = r_resp;
    assign pmem_rdata = r_rdata;
    assign pmem_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_pmem_responder.sv
// ============================================================================
// Module   : tb_pmem_responder
// Brief    : Scoreboard bench for pmem_responder (LATENCY=4, DEPTH_LINES=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmem_responder;

    localparam int c_LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         pmem_error;

    pmem_responder #(.LATENCY(c_LAT), .DEPTH_LINES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .pmem_error   (pmem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           exp_cyc;
        logic [255:0] exp_rdata;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [255:0] last_read = '0;

    localparam logic [255:0] c_DEAD = {8{32'hDEADBEEF}};
    localparam logic [255:0] c_1234 = {8{32'h12345678}};
    localparam logic [255:0] c_5555 = {8{32'h55555555}};
    localparam logic [255:0] c_AAAA = {8{32'hAAAAAAAA}};

    // Monitor: every response pulse must match the oldest outstanding expectation.
    exp_t m_e;
    always @(negedge clk) begin
        if (pmem_resp) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp: resp at cycle %0d, none outstanding", cyc);
            end else begin
                m_e = sb.pop_front();
                total += 2;
                if (cyc != m_e.exp_cyc) begin
                    bad++;
                    $display("FAIL %s_latency: resp cycle %0d, want %0d", m_e.name, cyc, m_e.exp_cyc);
                end
                if (pmem_rdata !== m_e.exp_rdata) begin
                    bad++;
                    $display("FAIL %s_rdata: got %h want %h", m_e.name, pmem_rdata, m_e.exp_rdata);
                end
            end
        end
    end

    task automatic check_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called on a negedge; the following posedge is the acceptance edge.
    task automatic drive(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                         input logic [255:0] exp_rd, input string nm);
        exp_t e;
        pmem_read    = !wr;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        e.exp_cyc    = cyc + 1 + c_LAT;
        e.exp_rdata  = wr ? last_read : exp_rd;
        e.name       = nm;
        sb.push_back(e);
        if (!wr) last_read = exp_rd;
    endtask

    task automatic wait_release(input int hold, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_resp && n < 50);
        if (!pmem_resp) begin
            total++; bad++;
            $display("FAIL %s_timeout: resp=0 after %0d cycles, want 1", nm, n);
            void'(sb.pop_back());
        end
        repeat (hold) @(negedge clk);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                         input logic [255:0] exp_rd, input int hold, input string nm);
        drive(wr, addr, wd, exp_rd, nm);
        wait_release(hold, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_address = '0; pmem_wdata = '0;
        repeat (3) @(negedge clk);
        check_bit("reset_resp",  pmem_resp,  1'b0);
        check_vec("reset_rdata", pmem_rdata, '0);
        check_bit("reset_error", pmem_error, 1'b0);
        rst_n = 1'b1;

        // First request on the first edge out of reset.
        do_op(1'b0, 32'h0000_0040, '0, '0, 0, "rd40");
        do_op(1'b1, 32'h0000_0060, c_DEAD, '0, 0, "wr60");
        do_op(1'b0, 32'h0000_0060, '0, c_DEAD, 0, "rd60");
        do_op(1'b0, 32'h0000_0080, '0, '0, 0, "rd80");
        do_op(1'b1, 32'h0000_0200, c_1234, '0, 0, "wr200");
        do_op(1'b0, 32'h0000_0000, '0, c_1234, 0, "rd0_alias");
        do_op(1'b0, 32'h0000_0060, '0, c_DEAD, 3, "rd60_held");
        do_op(1'b0, 32'h0000_0000, '0, c_1234, 0, "rd_after_hold");
        do_op(1'b1, 32'h0000_001F, c_5555, '0, 0, "wr0_lowbits");
        do_op(1'b0, 32'h0000_0200, '0, c_5555, 0, "rd200_alias");
        check_bit("no_error_yet", pmem_error, 1'b0);

        // Address changes mid-BUSY: flag error, complete with latched line.
        drive(1'b0, 32'h0000_0060, '0, c_DEAD, "rd_deviate");
        repeat (2) @(negedge clk);
        pmem_address = 32'h0000_0080;
        wait_release(0, "rd_deviate");
        check_bit("deviate_error", pmem_error, 1'b1);

        // Reset during BUSY of a write: no response, write discarded.
        pmem_write = 1'b1; pmem_address = 32'h0000_0020; pmem_wdata = c_AAAA;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; pmem_write = 1'b0;
        last_read = '0;
        repeat (8) @(negedge clk);
        check_bit("midreset_error", pmem_error, 1'b0);
        check_vec("midreset_rdata", pmem_rdata, '0);
        do_op(1'b0, 32'h0000_0020, '0, '0, 0, "rd20_after_reset");
        do_op(1'b0, 32'h0000_0060, '0, '0, 0, "rd60_cleared");

        // Both requests high in IDLE: error, nothing accepted.
        pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0040;
        repeat (4) @(negedge clk);
        check_bit("both_error", pmem_error, 1'b1);
        pmem_read = 1'b0; pmem_write = 1'b0;
        repeat (2) @(negedge clk);
        do_op(1'b0, 32'h0000_0040, '0, '0, 0, "rd_after_both");
        check_bit("error_sticky", pmem_error, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_bit("error_cleared", pmem_error, 1'b0);
        repeat (4) @(negedge clk);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL outstanding: %0d responses missing, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 8, cycles from request acceptance to resp; legal range 1..255.
REQ-002 Parameter DEPTH_LINES, default 16, number of 256-bit lines stored; power of two, 2..256.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 pmem_read  input  1  initiator read request, held high until resp is seen.
REQ-006 pmem_write  input  1  initiator write request, held high until resp is seen.
REQ-007 pmem_address  input  32  byte address; bits [4:0] ignored; line index = address[5+log2(DEPTH_LINES)-1:5].
REQ-008 pmem_wdata  input  256  write line; sampled at acceptance.
REQ-009 pmem_resp  output  1  one-cycle completion pulse.
REQ-010 pmem_rdata  output  256  read line; valid while pmem_resp is high.
REQ-011 pmem_error  output  1  sticky protocol-violation flag.

Function
REQ-012 States are IDLE, BUSY, RESP and DRAIN.
REQ-013 In IDLE with exactly one of pmem_read/pmem_write high, the block accepts the request: it latches the op, line index and wdata, and leaves IDLE at that edge (the acceptance edge).
REQ-014 pmem_resp is high for exactly the one cycle that begins LATENCY rising edges after the acceptance edge. For LATENCY=1 that is the cycle immediately after acceptance.
REQ-015 BUSY holds an 8-bit down-counter loaded at acceptance; BUSY -> RESP when the count expires; BUSY is skipped when LATENCY=1.
REQ-016 A write commits the latched wdata to the latched line at the edge entering RESP; a read issued afterward returns the new data.
REQ-017 For a read, pmem_rdata is loaded with the stored line at the edge entering RESP and holds its value until the next read response.
REQ-018 RESP -> DRAIN unconditionally. DRAIN -> IDLE only on an edge where pmem_read and pmem_write are both low, so a held request never triggers a second response.
REQ-019 Address bits above the index are ignored; lines alias modulo DEPTH_LINES.
REQ-020 pmem_read and pmem_write both high in IDLE: no request is accepted, pmem_error is set, and the block stays in IDLE.
REQ-021 In BUSY, if the asserted op deviates from the latched op or pmem_address[31:5] changes, pmem_error is set and the transaction still completes with the latched values.
REQ-022 pmem_error is cleared only by reset.
REQ-023 Requests arriving in BUSY, RESP or DRAIN are not queued.

Reset
REQ-024 While rst_n is low at an edge: state becomes IDLE, the counter is 0, pmem_resp=0, pmem_rdata=0, pmem_error=0, and every stored line is 0.
REQ-025 Reset in BUSY or RESP abandons the transaction: no resp is issued and a write not yet committed is discarded.
REQ-026 The first request can be accepted on the first edge with rst_n high.

Verification
REQ-027 LATENCY=4, after reset: read 0x00000040 accepted at edge E -> pmem_resp high only in the cycle after edge E+4, pmem_rdata=0.
REQ-028 Write 0x00000060 with wdata={8{32'hDEADBEEF}}, then read 0x00000060 -> rdata={8{32'hDEADBEEF}}; read 0x00000080 -> rdata=0.
REQ-029 DEPTH_LINES=16: write 0x00000200 with {8{32'h12345678}}, then read 0x00000000 -> rdata={8{32'h12345678}} (alias).
REQ-030 Initiator holds pmem_read for 3 cycles after resp -> exactly one resp, and the next request is accepted only after pmem_read drops.
REQ-031 pmem_read=pmem_write=1 in IDLE -> pmem_error=1, no resp; pmem_error stays 1 until rst_n=0.
REQ-032 rst_n=0 for one edge during BUSY of a write to 0x00000020 -> no resp; a later read of 0x00000020 returns 0.
